// File: rtl/record_sequencer_if.sv
// Bundle of request, tempo, note and buffer-write signals for record_sequencer.
// The sequencer takes the slave side; the controller or bench takes the master side.
interface record_sequencer_if;
    logic       start_in;
    logic       stop_in;
    logic [7:0] bpm_in;
    logic [5:0] note_in;
    logic       note_valid_in;
    logic       wr_en_out;
    logic [7:0] wr_addr_out;
    logic [5:0] wr_data_out;
    logic       beep_out;
    logic [1:0] state_out;
    logic [7:0] len_out;
    logic       done_out;

    modport slave (
        input  start_in, stop_in, bpm_in, note_in, note_valid_in,
        output wr_en_out, wr_addr_out, wr_data_out, beep_out, state_out, len_out, done_out
    );

    modport master (
        output start_in, stop_in, bpm_in, note_in, note_valid_in,
        input  wr_en_out, wr_addr_out, wr_data_out, beep_out, state_out, len_out, done_out
    );
endinterface

// File: rtl/record_sequencer.sv
// BPM-driven count-in and eighth-note record controller for the note buffer.
// Optional macro RECORD_SEQUENCER_METRONOME_EN keeps quarter beeps running while recording.
module record_sequencer #(
    parameter int unsigned CLK_HZ           = 74250000,
    parameter int unsigned DEPTH            = 160,
    parameter int unsigned COUNT_IN_EIGHTHS = 8,
    parameter int unsigned BEEP_CYCLES      = 1000000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    record_sequencer_if.slave bus
);

    // One eighth note is THRESH/bpm clocks: CLK_HZ * 60 / bpm / 2.
    localparam logic [32:0] THRESH    = 33'(CLK_HZ) * 33'd30;
    localparam logic [8:0]  CI_LAST   = 9'(COUNT_IN_EIGHTHS);
    localparam logic [7:0]  SLOT_LAST = 8'(DEPTH - 1);
    localparam logic [31:0] BEEP_LOAD = 32'(BEEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COUNT_IN = 2'd1,
        S_RECORD   = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  bpm_q, bpm_d;
    logic [31:0] acc_q, acc_d;
    logic [7:0]  ecnt_q, ecnt_d;
    logic [7:0]  slot_q, slot_d;
    logic        finish_q, finish_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [5:0]  wr_data_q, wr_data_d;
    logic [7:0]  len_q, len_d;
    logic        done_q, done_d;
    logic        beep_q, beep_d;
    logic [31:0] beep_cnt_q, beep_cnt_d;

    logic [32:0] sum;
    logic        tick;
    logic [31:0] acc_run;
    logic        start_ok;

    function automatic logic [7:0] clamp_bpm(input logic [7:0] b);
        if (b < 8'd30)       return 8'd30;
        else if (b > 8'd240) return 8'd240;
        else                 return b;
    endfunction

    assign sum      = {1'b0, acc_q} + {25'd0, bpm_q};
    assign tick     = (sum >= THRESH);
    assign acc_run  = tick ? 32'(sum - THRESH) : 32'(sum);
    assign start_ok = bus.start_in && !bus.stop_in;

    always_comb begin
        state_d    = state_q;
        bpm_d      = bpm_q;
        acc_d      = acc_q;
        ecnt_d     = ecnt_q;
        slot_d     = slot_q;
        finish_d   = finish_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        len_d      = len_q;
        done_d     = 1'b0;
        beep_d     = beep_q;
        beep_cnt_d = beep_cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                beep_d     = 1'b0;
                beep_cnt_d = 32'd0;
                if (start_ok) begin
                    bpm_d    = clamp_bpm(bus.bpm_in);
                    len_d    = 8'd0;
                    acc_d    = 32'd0;
                    ecnt_d   = 8'd0;
                    slot_d   = 8'd0;
                    finish_d = 1'b0;
                    if (CI_LAST == 9'd0) begin
                        state_d   = S_RECORD;
                        wr_addr_d = 8'd0;
                    end else begin
                        state_d = S_COUNT_IN;
                    end
                end
            end

            S_COUNT_IN: begin
                acc_d = acc_run;
                if (beep_cnt_q != 32'd0) beep_cnt_d = beep_cnt_q - 32'd1;
                else                     beep_d     = 1'b0;

                if (bus.stop_in) begin
                    state_d    = S_IDLE;
                    len_d      = 8'd0;
                    beep_d     = 1'b0;
                    beep_cnt_d = 32'd0;
                end else if (tick) begin
                    // Even pre-increment count marks a quarter-note boundary.
                    if (!ecnt_q[0]) begin
                        beep_d     = 1'b1;
                        beep_cnt_d = BEEP_LOAD;
                    end
                    ecnt_d = ecnt_q + 8'd1;
                    if (({1'b0, ecnt_q} + 9'd1) == CI_LAST) begin
                        state_d   = S_RECORD;
                        ecnt_d    = 8'd0;
                        slot_d    = 8'd0;
                        wr_addr_d = 8'd0;
`ifndef RECORD_SEQUENCER_METRONOME_EN
                        beep_d     = 1'b0;
                        beep_cnt_d = 32'd0;
`endif
                    end
                end
            end

            S_RECORD: begin
                acc_d = acc_run;
`ifdef RECORD_SEQUENCER_METRONOME_EN
                if (beep_cnt_q != 32'd0) beep_cnt_d = beep_cnt_q - 32'd1;
                else                     beep_d     = 1'b0;
`else
                beep_d     = 1'b0;
                beep_cnt_d = 32'd0;
`endif
                // finish_q: last write was issued last cycle, enter DONE now.
                if (finish_q) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    finish_d   = 1'b0;
                    beep_d     = 1'b0;
                    beep_cnt_d = 32'd0;
                end else if (tick) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = slot_q;
                    wr_data_d = bus.note_valid_in ? bus.note_in : 6'd0;
                    len_d     = slot_q + 8'd1;
                    slot_d    = slot_q + 8'd1;
`ifdef RECORD_SEQUENCER_METRONOME_EN
                    if (!slot_q[0]) begin
                        beep_d     = 1'b1;
                        beep_cnt_d = BEEP_LOAD;
                    end
`endif
                    if (bus.stop_in || (slot_q == SLOT_LAST)) finish_d = 1'b1;
                end else if (bus.stop_in) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    beep_d     = 1'b0;
                    beep_cnt_d = 32'd0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            bpm_q      <= 8'd0;
            acc_q      <= 32'd0;
            ecnt_q     <= 8'd0;
            slot_q     <= 8'd0;
            finish_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 6'd0;
            len_q      <= 8'd0;
            done_q     <= 1'b0;
            beep_q     <= 1'b0;
            beep_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            bpm_q      <= bpm_d;
            acc_q      <= acc_d;
            ecnt_q     <= ecnt_d;
            slot_q     <= slot_d;
            finish_q   <= finish_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            len_q      <= len_d;
            done_q     <= done_d;
            beep_q     <= beep_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign bus.wr_en_out   = wr_en_q;
    assign bus.wr_addr_out = wr_addr_q;
    assign bus.wr_data_out = wr_data_q;
    assign bus.beep_out    = beep_q;
    assign bus.state_out   = state_q;
    assign bus.len_out     = len_q;
    assign bus.done_out    = done_q;

endmodule

// File: tb/tb_record_sequencer.sv
// Directed bench for record_sequencer: CLK_HZ=100 (THRESH=3000), DEPTH=4, 8-eighth count-in.
// Cycle numbers are counted from the clock edge that samples start_in (edge 0).
module tb_record_sequencer;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    record_sequencer_if bus();

    record_sequencer #(
        .CLK_HZ(100),
        .DEPTH(4),
        .COUNT_IN_EIGHTHS(8),
        .BEEP_CYCLES(10)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    int wr_cyc[$];
    int wr_adr[$];
    int wr_dat[$];
    int beep_rise[$];
    int done_cyc[$];
    int state_log[0:1300];
    int beep_in_rec;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    function automatic int qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    // Note pattern keyed on the sampling edge: slot writes at 450/500/550/600
    // see note 5, a rest (17 not valid), 17 valid, then 33.
    task automatic drive_notes(input int i);
        if (i <= 450)      begin bus.note_in = 6'd5;  bus.note_valid_in = 1'b1; end
        else if (i <= 500) begin bus.note_in = 6'd17; bus.note_valid_in = 1'b0; end
        else if (i <= 550) begin bus.note_in = 6'd17; bus.note_valid_in = 1'b1; end
        else               begin bus.note_in = 6'd33; bus.note_valid_in = 1'b1; end
    endtask

    task automatic run_take(input logic [7:0] bpm, input int ncyc, input int stop_at, input int restart_at);
        logic prev_beep;
        wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
        beep_rise.delete(); done_cyc.delete();
        beep_in_rec = 0;
        for (int k = 0; k <= 1300; k++) state_log[k] = -1;
        bus.bpm_in   = bpm;
        bus.start_in = 1'b1;
        @(posedge clk_in); #1;
        bus.start_in = 1'b0;
        prev_beep = bus.beep_out;
        for (int i = 1; i <= ncyc; i++) begin
            drive_notes(i);
            bus.stop_in  = (i == stop_at);
            bus.start_in = (i == restart_at);
            @(posedge clk_in); #1;
            state_log[i] = int'(bus.state_out);
            if (bus.wr_en_out) begin
                wr_cyc.push_back(i);
                wr_adr.push_back(int'(bus.wr_addr_out));
                wr_dat.push_back(int'(bus.wr_data_out));
            end
            if (bus.beep_out && !prev_beep) beep_rise.push_back(i);
            if (bus.beep_out && bus.state_out == 2'd2) beep_in_rec++;
            if (bus.done_out) done_cyc.push_back(i);
            prev_beep = bus.beep_out;
        end
        bus.stop_in  = 1'b0;
        bus.start_in = 1'b0;
    endtask

    initial begin
        bus.start_in = 1'b0;
        bus.stop_in = 1'b0;
        bus.bpm_in = 8'd60;
        bus.note_in = 6'd0;
        bus.note_valid_in = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check_eq("rst_state", int'(bus.state_out), 0);
        check_eq("rst_len", int'(bus.len_out), 0);
        check_eq("rst_wr_en", int'(bus.wr_en_out), 0);
        check_eq("rst_beep", int'(bus.beep_out), 0);
        check_eq("rst_done", int'(bus.done_out), 0);
        check_eq("rst_wr_addr", int'(bus.wr_addr_out), 0);
        rst_in = 1'b0;

        // start and stop together in IDLE: stop wins
        bus.start_in = 1'b1; bus.stop_in = 1'b1;
        @(posedge clk_in); #1;
        bus.start_in = 1'b0; bus.stop_in = 1'b0;
        check_eq("startstop_idle", int'(bus.state_out), 0);
        repeat (5) @(posedge clk_in);
        #1;
        check_eq("startstop_idle_later", int'(bus.state_out), 0);

        // Full take at 60 BPM: eighth every 50 cycles
        run_take(8'd60, 650, 0, 0);
        check_eq("t1_state_c1", state_log[1], 1);
        check_eq("t1_state_c399", state_log[399], 1);
        check_eq("t1_state_c400", state_log[400], 2);
        check_eq("t1_wr_count", wr_cyc.size(), 4);
        check_eq("t1_wr0_cyc", qget(wr_cyc, 0), 450);
        check_eq("t1_wr1_cyc", qget(wr_cyc, 1), 500);
        check_eq("t1_wr2_cyc", qget(wr_cyc, 2), 550);
        check_eq("t1_wr3_cyc", qget(wr_cyc, 3), 600);
        check_eq("t1_wr0_addr", qget(wr_adr, 0), 0);
        check_eq("t1_wr3_addr", qget(wr_adr, 3), 3);
        check_eq("t2_wr0_data", qget(wr_dat, 0), 5);
        check_eq("t2_wr1_rest", qget(wr_dat, 1), 0);
        check_eq("t2_wr2_data", qget(wr_dat, 2), 17);
        check_eq("t2_wr3_data", qget(wr_dat, 3), 33);
        check_eq("t1_done_count", done_cyc.size(), 1);
        check_eq("t1_done_cyc", qget(done_cyc, 0), 601);
        check_eq("t1_len", int'(bus.len_out), 4);
        check_eq("t1_state_end", int'(bus.state_out), 3);
        check_eq("t1_beep1", qget(beep_rise, 0), 50);
        check_eq("t1_beep2", qget(beep_rise, 1), 150);
        check_eq("t1_beep4", qget(beep_rise, 3), 350);
`ifdef RECORD_SEQUENCER_METRONOME_EN
        check_eq("t6_beep_rises", beep_rise.size(), 6);
        check_eq("t6_beep_slot0", qget(beep_rise, 4), 450);
        check_eq("t6_beep_slot2", qget(beep_rise, 5), 550);
`else
        check_eq("t6_beep_rises", beep_rise.size(), 4);
        check_eq("t6_beep_in_rec", beep_in_rec, 0);
`endif

        // bpm 10 clamps to 30: eighth every 100 cycles; stop in RECORD to finish
        run_take(8'd10, 820, 820, 0);
        check_eq("t3a_beep1", qget(beep_rise, 0), 100);
        check_eq("t3a_state_c799", state_log[799], 1);
        check_eq("t3a_state_c800", state_log[800], 2);
        check_eq("t3a_stop_done", int'(bus.state_out), 3);
        check_eq("t3a_len", int'(bus.len_out), 0);

        // bpm 250 clamps to 240: 12.5 cycles per eighth
        run_take(8'd250, 160, 0, 0);
        check_eq("t3b_beep1", qget(beep_rise, 0), 13);
        check_eq("t3b_beep2", qget(beep_rise, 1), 38);
        check_eq("t3b_state_c99", state_log[99], 1);
        check_eq("t3b_state_c100", state_log[100], 2);
        check_eq("t3b_wr0_cyc", qget(wr_cyc, 0), 113);
        check_eq("t3b_wr1_cyc", qget(wr_cyc, 1), 125);
        check_eq("t3b_wr3_cyc", qget(wr_cyc, 3), 150);
        check_eq("t3b_done_cyc", qget(done_cyc, 0), 151);
        check_eq("t3b_len", int'(bus.len_out), 4);

        // stop during count-in
        run_take(8'd60, 200, 120, 0);
        check_eq("t4a_state_c119", state_log[119], 1);
        check_eq("t4a_state_c120", state_log[120], 0);
        check_eq("t4a_wr_count", wr_cyc.size(), 0);
        check_eq("t4a_len", int'(bus.len_out), 0);
        check_eq("t4a_beep_end", int'(bus.beep_out), 0);
        check_eq("t4a_done_count", done_cyc.size(), 0);

        // stop coincident with the second RECORD tick
        run_take(8'd60, 560, 500, 0);
        check_eq("t4b_wr_count", wr_cyc.size(), 2);
        check_eq("t4b_wr1_cyc", qget(wr_cyc, 1), 500);
        check_eq("t4b_wr1_addr", qget(wr_adr, 1), 1);
        check_eq("t4b_done_cyc", qget(done_cyc, 0), 501);
        check_eq("t4b_len", int'(bus.len_out), 2);
        check_eq("t4b_state", int'(bus.state_out), 3);

        // start during RECORD ignored, then asynchronous reset mid-RECORD
        run_take(8'd60, 520, 0, 460);
        check_eq("t5_wr_count", wr_cyc.size(), 2);
        check_eq("t5_wr1_addr", qget(wr_adr, 1), 1);
        check_eq("t5_pre_state", int'(bus.state_out), 2);
        check_eq("t5_pre_len", int'(bus.len_out), 2);
        #2;
        rst_in = 1'b1;
        #1;
        check_eq("t5_async_state", int'(bus.state_out), 0);
        check_eq("t5_async_len", int'(bus.len_out), 0);
        check_eq("t5_async_addr", int'(bus.wr_addr_out), 0);
        check_eq("t5_async_wr_en", int'(bus.wr_en_out), 0);
        check_eq("t5_async_beep", int'(bus.beep_out), 0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
